// File: rtl/simon_arb_pkg.sv
// simon_arb_pkg: shared types and defaults for the SIMON core arbiter.
package simon_arb_pkg;

    localparam int unsigned TO_CYC_DEF = 255;
    localparam int unsigned TOW_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_KWAIT,
        ST_DATA,
        ST_RUN,
        ST_READ,
        ST_ERR
    } arb_state_t;

    // One-hot requester mask from a requester index.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/simon_rr_pick.sv
// simon_rr_pick: two-way round-robin choice; on a tie the requester that
// was not served last wins.
module simon_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick_c,
    output logic       any_c
);

    // Tie goes to the requester other than the last one served.
    always_comb begin
        any_c  = |req;
        pick_c = 1'b0;
        if (req == 2'b11) begin
            pick_c = ~last;
        end else begin
            pick_c = req[1];
        end
    end

endmodule

// File: rtl/simon_core_arbiter.sv
// simon_core_arbiter: shares one SIMON cipher core between two requesters,
// sequencing key load, data load, run and readout with a per-wait watchdog.
// Optional key cache: define SIMON_ARB_KEYCACHE_EN to skip the key load when
// the granted requester already owns the loaded key and its key is unchanged.
module simon_core_arbiter
    import simon_arb_pkg::*;
#(
    parameter int unsigned TO_CYC = TO_CYC_DEF,
    parameter int unsigned TOW    = TOW_DEF
) (
    input  logic       clk,
    input  logic       R,
    input  logic [1:0] req,
    input  logic [1:0] keyChg,
    input  logic [1:0] encDec,
    output logic [1:0] grant,
    output logic       sel,
    output logic [1:0] rspValid,
    output logic [1:0] err,
    output logic       busy,
    output logic       newKey,
    output logic       newData,
    output logic       enc_dec,
    output logic       readData,
    input  logic       loadKey,
    input  logic       loadData,
    input  logic       doneKey,
    input  logic       doneData
);

    arb_state_t      state;
    logic [TOW-1:0]  wdog;
    logic            last_srv;
    logic            enc_lat;
    logic            pick_c;
    logic            any_c;
    logic            wdog_hit_c;

`ifdef SIMON_ARB_KEYCACHE_EN
    logic            kh_valid;
    logic            kh_id;
    logic            key_hit_c;

    // Loaded key already belongs to the candidate and is unchanged.
    assign key_hit_c = kh_valid && (kh_id == pick_c) && !keyChg[pick_c];
`else
    logic            unused_keychg;

    assign unused_keychg = ^keyChg;
`endif

    simon_rr_pick u_pick (
        .req    (req),
        .last   (last_srv),
        .pick_c (pick_c),
        .any_c  (any_c)
    );

    // Current wait has lasted TO_CYC cycles without the awaited event.
    assign wdog_hit_c = (wdog == TOW'(TO_CYC - 1));

    // Transaction sequencer with registered core controls and responses.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state    <= ST_IDLE;
            wdog     <= '0;
            last_srv <= 1'b1;
            enc_lat  <= 1'b0;
            grant    <= 2'b00;
            sel      <= 1'b0;
            rspValid <= 2'b00;
            err      <= 2'b00;
            busy     <= 1'b0;
            newKey   <= 1'b0;
            newData  <= 1'b0;
            enc_dec  <= 1'b0;
            readData <= 1'b0;
`ifdef SIMON_ARB_KEYCACHE_EN
            kh_valid <= 1'b0;
            kh_id    <= 1'b0;
`endif
        end else begin
            wdog     <= '0;
            rspValid <= 2'b00;
            err      <= 2'b00;
            readData <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_c) begin
                        grant    <= onehot2(pick_c);
                        sel      <= pick_c;
                        last_srv <= pick_c;
                        enc_lat  <= encDec[pick_c];
                        busy     <= 1'b1;
`ifdef SIMON_ARB_KEYCACHE_EN
                        if (key_hit_c) begin
                            state   <= ST_DATA;
                            newData <= 1'b1;
                            enc_dec <= encDec[pick_c];
                        end else begin
                            state   <= ST_KEY;
                            newKey  <= 1'b1;
                        end
`else
                        state  <= ST_KEY;
                        newKey <= 1'b1;
`endif
                    end
                end
                ST_KEY: begin
                    if (loadKey) begin
                        newKey <= 1'b0;
                        state  <= ST_KWAIT;
                    end else if (wdog_hit_c) begin
                        newKey <= 1'b0;
                        err    <= onehot2(sel);
                        state  <= ST_ERR;
                    end else begin
                        wdog <= wdog + TOW'(1);
                    end
                end
                ST_KWAIT: begin
                    if (doneKey) begin
                        newData <= 1'b1;
                        enc_dec <= enc_lat;
                        state   <= ST_DATA;
`ifdef SIMON_ARB_KEYCACHE_EN
                        kh_valid <= 1'b1;
                        kh_id    <= sel;
`endif
                    end else if (wdog_hit_c) begin
                        err   <= onehot2(sel);
                        state <= ST_ERR;
                    end else begin
                        wdog <= wdog + TOW'(1);
                    end
                end
                ST_DATA: begin
                    if (loadData) begin
                        newData <= 1'b0;
                        state   <= ST_RUN;
                    end else if (wdog_hit_c) begin
                        newData <= 1'b0;
                        err     <= onehot2(sel);
                        state   <= ST_ERR;
                    end else begin
                        wdog <= wdog + TOW'(1);
                    end
                end
                ST_RUN: begin
                    if (doneData) begin
                        readData <= 1'b1;
                        rspValid <= onehot2(sel);
                        state    <= ST_READ;
                    end else if (wdog_hit_c) begin
                        err   <= onehot2(sel);
                        state <= ST_ERR;
                    end else begin
                        wdog <= wdog + TOW'(1);
                    end
                end
                ST_READ: begin
                    grant   <= 2'b00;
                    busy    <= 1'b0;
                    enc_dec <= 1'b0;
                    state   <= ST_IDLE;
                end
                ST_ERR: begin
                    grant   <= 2'b00;
                    busy    <= 1'b0;
                    enc_dec <= 1'b0;
                    state   <= ST_IDLE;
`ifdef SIMON_ARB_KEYCACHE_EN
                    kh_valid <= 1'b0;
`endif
                end
                default: begin
                    grant   <= 2'b00;
                    busy    <= 1'b0;
                    newKey  <= 1'b0;
                    newData <= 1'b0;
                    enc_dec <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_core_arbiter.sv
// tb_simon_core_arbiter: directed and randomized checks of the core arbiter
// against a table-driven transaction model.
module tb_simon_core_arbiter;

    localparam int TO_CYC = 255;

    logic       clk = 1'b0;
    logic       R   = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] keyChg = 2'b00;
    logic [1:0] encDec = 2'b00;
    logic [3:0] core_st = 4'b0000;   // {doneData, loadData, doneKey, loadKey}

    logic [1:0] grant;
    logic       sel;
    logic [1:0] rspValid;
    logic [1:0] err;
    logic       busy;
    logic       newKey;
    logic       newData;
    logic       enc_dec;
    logic       readData;

    int n_checks = 0;
    int n_fail   = 0;

    simon_core_arbiter dut (
        .clk      (clk),
        .R        (R),
        .req      (req),
        .keyChg   (keyChg),
        .encDec   (encDec),
        .grant    (grant),
        .sel      (sel),
        .rspValid (rspValid),
        .err      (err),
        .busy     (busy),
        .newKey   (newKey),
        .newData  (newData),
        .enc_dec  (enc_dec),
        .readData (readData),
        .loadKey  (core_st[0]),
        .loadData (core_st[2]),
        .doneKey  (core_st[1]),
        .doneData (core_st[3])
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Transaction model: a transaction is a list of four handshakes
    // (loadKey, doneKey, loadData, doneData), each awaited for at most TO_CYC
    // cycles; step 4 means the owner's last cycle (response or abort).
    int  m_owner = -1;
    int  m_step  = 4;
    bit  m_read  = 1'b0;
    bit  m_abort = 1'b0;
    int  m_wait  = 0;
    int  m_last  = 1;
    bit  m_enc   = 1'b0;
    int  m_pick;
`ifdef SIMON_ARB_KEYCACHE_EN
    bit  m_kvalid = 1'b0;
    int  m_kid    = 0;
`endif

    always @(posedge clk or posedge R) begin
        if (R) begin
            m_owner = -1; m_step = 4; m_read = 1'b0; m_abort = 1'b0;
            m_wait = 0; m_last = 1; m_enc = 1'b0;
`ifdef SIMON_ARB_KEYCACHE_EN
            m_kvalid = 1'b0; m_kid = 0;
`endif
        end else if (m_owner < 0) begin
            m_pick = -1;
            if (req == 2'b11)   m_pick = 1 - m_last;
            else if (req[1])    m_pick = 1;
            else if (req[0])    m_pick = 0;
            if (m_pick >= 0) begin
                m_owner = m_pick;
                m_last  = m_pick;
                m_enc   = encDec[m_pick];
                m_wait  = 0;
                m_step  = 0;
`ifdef SIMON_ARB_KEYCACHE_EN
                if (m_kvalid && m_kid == m_pick && !keyChg[m_pick]) m_step = 2;
`endif
            end
        end else if (m_read || m_abort) begin
            m_owner = -1; m_read = 1'b0; m_abort = 1'b0; m_step = 4;
`ifdef SIMON_ARB_KEYCACHE_EN
            if (m_abort == 1'b0 && m_step == 4) m_kvalid = m_kvalid;
`endif
        end else if (core_st[m_step]) begin
`ifdef SIMON_ARB_KEYCACHE_EN
            if (m_step == 1) begin m_kvalid = 1'b1; m_kid = m_owner; end
`endif
            if (m_step == 3) begin m_read = 1'b1; m_step = 4; end
            else m_step++;
            m_wait = 0;
        end else begin
            m_wait++;
            if (m_wait == TO_CYC) begin
                m_abort = 1'b1;
                m_step  = 4;
`ifdef SIMON_ARB_KEYCACHE_EN
                m_kvalid = 1'b0;
`endif
            end
        end
    end

    logic [1:0] x_mask;

    // Every cycle, compare all outputs with the model's view.
    always @(negedge clk) begin
        if (!R) begin
            x_mask = (m_owner == 1) ? 2'b10 : 2'b01;
            check("m_grant",    32'(grant),    (m_owner >= 0) ? 32'(x_mask) : 32'd0);
            check("m_busy",     32'(busy),     32'(m_owner >= 0));
            check("m_newKey",   32'(newKey),   32'(m_owner >= 0 && m_step == 0));
            check("m_newData",  32'(newData),  32'(m_owner >= 0 && m_step == 2));
            check("m_readData", 32'(readData), 32'(m_read));
            check("m_rspValid", 32'(rspValid), m_read  ? 32'(x_mask) : 32'd0);
            check("m_err",      32'(err),      m_abort ? 32'(x_mask) : 32'd0);
            if (m_owner >= 0) check("m_sel", 32'(sel), 32'(m_owner));
            if (m_owner >= 0 && (m_step == 2 || m_step == 3 || m_read))
                check("m_enc_dec", 32'(enc_dec), 32'(m_enc));
        end
    end

    // Pulse the first n core handshakes in order, d idle cycles before each.
    task automatic serve_n(input int n, input int d);
        for (int i = 0; i < n; i++) begin
            repeat (d) @(negedge clk);
            core_st[i] = 1'b1;
            @(negedge clk);
            core_st[i] = 1'b0;
        end
    endtask

    task automatic wait_grant(input logic [1:0] exp, input string nm, output int lat);
        lat = 0;
        @(negedge clk);
        while (grant == 2'b00 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(nm, 32'(grant), 32'(exp));
    endtask

    int lat;
    int n;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", 32'({newKey, newData, enc_dec, readData, rspValid, err, sel}), 32'd0);
        R = 1'b0;
        @(negedge clk);
        check("idle_grant", 32'(grant), 32'd0);

        // Single transaction from requester 0
        req = 2'b01; keyChg = 2'b00; encDec = 2'b01;
        wait_grant(2'b01, "t1_grant", lat);
        check("t1_latency", 32'(lat), 32'd0);
        check("t1_newKey", 32'(newKey), 32'd1);
        serve_n(2, 0);
        check("t1_newData", 32'(newData), 32'd1);
        check("t1_enc", 32'(enc_dec), 32'd1);
        encDec = 2'b00;
        core_st[2] = 1'b1; @(negedge clk); core_st[2] = 1'b0;
        check("t1_enc_run", 32'(enc_dec), 32'd1);
        core_st[3] = 1'b1; @(negedge clk); core_st[3] = 1'b0;
        check("t1_readData", 32'(readData), 32'd1);
        check("t1_rsp", 32'(rspValid), 32'd1);
        req = 2'b00;
        @(negedge clk);
        check("t1_rsp_once", 32'(rspValid), 32'd0);
        check("t1_grant_clr", 32'(grant), 32'd0);
        check("t1_busy_clr", 32'(busy), 32'd0);

        // Simultaneous requests after requester 0 was served
        req = 2'b11;
        wait_grant(2'b10, "rr_first", lat);
        serve_n(4, 0);
        check("rr_rsp1", 32'(rspValid), 32'd2);
        req = 2'b01;
        wait_grant(2'b01, "rr_second", lat);
        check("rr_second_lat", 32'(lat), 32'd1);
        serve_n(4, 1);
        check("rr_rsp0", 32'(rspValid), 32'd1);
        req = 2'b00;

        // Repeat by the key owner with unchanged key
        @(negedge clk);
        req = 2'b01; keyChg = 2'b00;
        wait_grant(2'b01, "kc_grant", lat);
`ifdef SIMON_ARB_KEYCACHE_EN
        check("kc_newKey", 32'(newKey), 32'd0);
        check("kc_newData", 32'(newData), 32'd1);
`else
        check("kc_newKey", 32'(newKey), 32'd1);
        check("kc_newData", 32'(newData), 32'd0);
`endif
        serve_n(4, 0);
        req = 2'b00;

        // Request dropped while the core runs
        @(negedge clk);
        req = 2'b01; keyChg = 2'b01;
        wait_grant(2'b01, "drop_grant", lat);
        serve_n(3, 0);
        req = 2'b00; keyChg = 2'b00;
        core_st[3] = 1'b1; @(negedge clk); core_st[3] = 1'b0;
        check("drop_read", 32'(readData), 32'd1);
        check("drop_rsp", 32'(rspValid), 32'd1);
        @(negedge clk);
        check("drop_rsp_once", 32'(rspValid), 32'd0);

        // Watchdog on a withheld doneData
        req = 2'b01;
        wait_grant(2'b01, "to_grant", lat);
        serve_n(3, 0);
        n = 0;
        while (err == 2'b00 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("to_err", 32'(err), 32'd1);
        check("to_cycles", 32'(n), 32'd255);
        req = 2'b00;
        @(negedge clk);
        check("to_err_once", 32'(err), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        req = 2'b01;
        wait_grant(2'b01, "to_regrant", lat);
        check("to_rekey", 32'(newKey), 32'd1);
        serve_n(4, 0);
        req = 2'b00;

        // Asynchronous reset mid-run
        @(negedge clk);
        req = 2'b01;
        wait_grant(2'b01, "ar_grant", lat);
        serve_n(3, 0);
        #2 R = 1'b1;
        #1;
        check("ar_grant0", 32'(grant), 32'd0);
        check("ar_busy0", 32'(busy), 32'd0);
        check("ar_outs0", 32'({newKey, newData, enc_dec, readData, rspValid, err}), 32'd0);
        @(negedge clk);
        R = 1'b0;
        wait_grant(2'b01, "ar_regrant", lat);
        check("ar_newKey", 32'(newKey), 32'd1);
        serve_n(4, 0);
        req = 2'b00;

        // Random traffic: busy core, then a sluggish core that times out
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < ((ph == 0) ? 4000 : 2000); c++) begin
                @(negedge clk);
                R = 1'b0;
                req    = 2'($urandom_range(0, 3));
                keyChg = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
                encDec = 2'($urandom_range(0, 3));
                for (int b = 0; b < 4; b++)
                    core_st[b] = ($urandom_range(0, 99) < ((ph == 0) ? 35 : 1));
                if ($urandom_range(0, 799) == 0) begin
                    #2 R = 1'b1;
                end
            end
        end
        @(negedge clk);
        R = 1'b0; req = 2'b00; core_st = 4'b0000;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout at %0t: bench did not finish", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/simon_core_arbiter.md
SIMON_CORE_ARBITER -- requirements
Module: simon_core_arbiter

Interface
REQ-001 Parameter TO_CYC, default 255: watchdog limit in cycles for any single wait on the core.
REQ-002 Parameter TOW, default 8: watchdog counter width; TO_CYC SHALL be less than 2**TOW.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 R  in  1  reset, asynchronous, active-high.
REQ-005 req  in  2  per-requester transaction request; held high until its rsp_valid.
REQ-006 keyChg  in  2  requester's key differs from the key it last loaded.
REQ-007 encDec  in  2  per-requester encrypt(1)/decrypt(0) select.
REQ-008 grant  out  2  one-hot owner of the core; all-zero when idle.
REQ-009 sel  out  1  index of granted requester; drives external block/key muxes.
REQ-010 rspValid  out  2  one-cycle pulse to owner: result on core outData.
REQ-011 err  out  2  one-cycle pulse to owner: transaction aborted by watchdog.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 newKey, newData, enc_dec, readData  out  1 each  core control.
REQ-014 loadKey, loadData, doneKey, doneData  in  1 each  core status.

Function
REQ-015 States: IDLE, KEY, KWAIT, DATA, RUN, READ, ERR.
REQ-016 IDLE: any req high -> grant in next cycle, latch sel/encDec, go to KEY (or DATA per REQ-024).
REQ-017 Both req high in IDLE: grant the requester not served last; pointer updates on every grant.
REQ-018 KEY: newKey high until loadKey seen; newKey low on cycle after loadKey, go KWAIT.
REQ-019 KWAIT: wait doneKey, then DATA; record owner as key holder.
REQ-020 DATA: newData high, enc_dec = latched encDec, until loadData; then RUN.
REQ-021 RUN: wait doneData; then READ.
REQ-022 READ: readData high exactly one cycle; rspValid[sel] pulses same cycle; grant clears next cycle; return IDLE.
REQ-023 Dropping req mid-transaction SHALL NOT abort; transaction completes and rspValid still pulses.
REQ-024 Watchdog: counter clears on state entry; reaching TO_CYC in KEY/KWAIT/DATA/RUN -> ERR; ERR pulses err[sel] one cycle, invalidates key holder, returns IDLE.
REQ-025 Request from the non-owner during a transaction waits; it is granted on the cycle after return to IDLE, ahead of the last-served requester.
REQ-026 enc_dec SHALL be stable from DATA entry through READ.

Reset
REQ-027 R high: state IDLE, all outputs 0, pointer favours requester 0, key holder invalid, watchdog 0; effective immediately, including mid-transaction.
REQ-028 First grant after reset release SHALL go through KEY regardless of keyChg.

Configuration
REQ-029 Macro SIMON_ARB_KEYCACHE_EN defined: IDLE goes directly to DATA when granted requester equals valid key holder and its keyChg is low.
REQ-030 Macro undefined: every transaction passes through KEY and KWAIT; key holder tracking removed.

Structure
REQ-031 Package simon_arb_pkg holds state enum, TO_CYC and TOW defaults.
REQ-032 Sub-module simon_rr_pick: 2-way round-robin pick from req and last-served pointer, combinational.

Verification
REQ-033 Reset, req=01, keyChg=00 -> grant=01 next cycle, newKey asserted, rspValid=01 one pulse after doneData.
REQ-034 req=11 simultaneous after requester 0 served -> grant=10 first, then 01 after its rspValid.
REQ-035 Keycache on, requester 0 repeats with keyChg=0 -> IDLE->DATA, newKey never asserted; macro off -> newKey asserted.
REQ-036 doneData withheld 255 cycles -> err=01 one pulse, busy low next cycle, next transaction reloads key.
REQ-037 R pulsed during RUN -> all outputs 0 asynchronously, grant=00, next request enters KEY.
REQ-038 req[0] dropped during RUN -> readData and rspValid[0] still pulse once.
